// File: rtl/fan_timer_pkg.sv
// Shared types and constants for the fan auto-off timer: FSM encoding,
// mode codes and the mode-to-duration lookup.
package fan_timer_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_EXPIRE = 2'd2
  } timer_state_e;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_1   = 2'd1;
  localparam logic [1:0] MODE_2   = 2'd2;
  localparam logic [1:0] MODE_3   = 2'd3;

  // Durations are passed in so the function stays independent of any one
  // instance's parameter set; MODE_OFF maps to zero seconds.
  function automatic int unsigned mode_duration(
    input logic [1:0]  mode,
    input int unsigned t1_s,
    input int unsigned t2_s,
    input int unsigned t3_s
  );
    int unsigned dur;
    dur = 0;
    case (mode)
      MODE_1:  dur = t1_s;
      MODE_2:  dur = t2_s;
      MODE_3:  dur = t3_s;
      default: dur = 0;
    endcase
    return dur;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second (or any period) tick prescaler: counts 0..TICK_CYCLES-1 while
// enabled and flags the last count combinationally.
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 125_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/fan_off_timer.sv
// Fan auto-off timer: a button cycles through three preset durations, the
// selection counts down in seconds and a one-cycle set_idle pulse fires on expiry.
module fan_off_timer
  import fan_timer_pkg::*;
#(
  parameter int unsigned SYS_FREQ    = 125,
  parameter int unsigned TICK_CYCLES = 125_000_000,
  parameter int unsigned T1_S        = 60,
  parameter int unsigned T2_S        = 180,
  parameter int unsigned T3_S        = 300,
  parameter int unsigned W           = 9
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         btn_timer,
  input  logic         fan_en,
  output logic         set_idle,
  output logic [1:0]   timer_mode,
  output logic [W-1:0] remain_s,
  output logic         timer_active
);

  if ((T1_S >= (64'd1 << W)) || (T2_S >= (64'd1 << W)) || (T3_S >= (64'd1 << W))) begin : g_bad_width
    $error("fan_off_timer: a preset duration does not fit in W bits");
  end

  if ((SYS_FREQ == 0) || (TICK_CYCLES == 0)) begin : g_bad_clock
    $error("fan_off_timer: SYS_FREQ and TICK_CYCLES must be non-zero");
  end

  timer_state_e state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [W-1:0] remain_q, remain_d;
  logic         set_idle_q, set_idle_d;
  logic         active_q, active_d;
  logic         reload;
  logic         tick_clr;
  logic         tick;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk    (clk),
    .reset_p(reset_p),
    .clr    (tick_clr),
    .en     (state_q == ST_RUN),
    .tick   (tick)
  );

  // Priority: fan_en low > button > tick. A reload swallows a coincident tick.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    remain_d   = remain_q;
    set_idle_d = 1'b0;
    reload     = 1'b0;

    if (!fan_en) begin
      state_d  = ST_OFF;
      mode_d   = MODE_OFF;
      remain_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (btn_timer) begin
            state_d  = ST_RUN;
            mode_d   = MODE_1;
            remain_d = W'(mode_duration(MODE_1, T1_S, T2_S, T3_S));
            reload   = 1'b1;
          end
        end

        ST_RUN: begin
          if (btn_timer) begin
            case (mode_q)
              MODE_1: begin
                mode_d   = MODE_2;
                remain_d = W'(mode_duration(MODE_2, T1_S, T2_S, T3_S));
                reload   = 1'b1;
              end
              MODE_2: begin
                mode_d   = MODE_3;
                remain_d = W'(mode_duration(MODE_3, T1_S, T2_S, T3_S));
                reload   = 1'b1;
              end
              default: begin
                state_d  = ST_OFF;
                mode_d   = MODE_OFF;
                remain_d = '0;
              end
            endcase
          end else if (tick) begin
            if (remain_q <= W'(1)) begin
              state_d    = ST_EXPIRE;
              remain_d   = '0;
              set_idle_d = 1'b1;
            end else begin
              remain_d = remain_q - W'(1);
            end
          end
        end

        ST_EXPIRE: begin
          state_d  = ST_OFF;
          mode_d   = MODE_OFF;
          remain_d = '0;
        end

        default: begin
          state_d  = ST_OFF;
          mode_d   = MODE_OFF;
          remain_d = '0;
        end
      endcase
    end

    active_d = (state_d == ST_RUN);
  end

  // The prescaler restarts on every reload and sits at zero outside RUN.
  assign tick_clr = reload || (state_d != ST_RUN);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= ST_OFF;
      mode_q     <= MODE_OFF;
      remain_q   <= '0;
      set_idle_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      remain_q   <= remain_d;
      set_idle_q <= set_idle_d;
      active_q   <= active_d;
    end
  end

  assign set_idle     = set_idle_q;
  assign timer_mode   = mode_q;
  assign remain_s     = remain_q;
  assign timer_active = active_q;

endmodule

// File: tb/tb_fan_off_timer.sv
// Directed bench for fan_off_timer with a 4-cycle tick and 3/5/7 s presets.
module tb_fan_off_timer;

  localparam int unsigned W = 9;

  logic         clk;
  logic         reset_p;
  logic         btn_timer;
  logic         fan_en;
  logic         set_idle;
  logic [1:0]   timer_mode;
  logic [W-1:0] remain_s;
  logic         timer_active;

  int n_checks;
  int n_bad;

  fan_off_timer #(
    .SYS_FREQ   (125),
    .TICK_CYCLES(4),
    .T1_S       (3),
    .T2_S       (5),
    .T3_S       (7),
    .W          (W)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .btn_timer   (btn_timer),
    .fan_en      (fan_en),
    .set_idle    (set_idle),
    .timer_mode  (timer_mode),
    .remain_s    (remain_s),
    .timer_active(timer_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: observed=%0d required=%0d", tag, observed, expected);
    end
  endtask

  // Drive inputs, then let one active edge pass and settle just after it.
  task automatic applyStimulus(input logic btn, input logic fan);
    btn_timer = btn;
    fan_en    = fan;
    @(posedge clk);
    #1;
    btn_timer = 1'b0;
  endtask

  task automatic checkAll(input string tag, input int mode, input int remain, input int idle, input int active);
    checkOutput({tag, ".mode"},   32'(timer_mode),   32'(mode));
    checkOutput({tag, ".remain"}, 32'(remain_s),     32'(remain));
    checkOutput({tag, ".idle"},   32'(set_idle),     32'(idle));
    checkOutput({tag, ".active"}, 32'(timer_active), 32'(active));
  endtask

  initial begin
    n_checks  = 0;
    n_bad     = 0;
    reset_p   = 1'b1;
    btn_timer = 1'b0;
    fan_en    = 1'b1;
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    checkAll("reset", 0, 0, 0, 0);
    reset_p = 1'b0;

    // Single press: 3 s countdown, expiry pulse 12 cycles after load.
    applyStimulus(1, 1);
    checkAll("load1", 1, 3, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 1);
      checkOutput($sformatf("count%0d.remain", k), 32'(remain_s), 32'(3 - k / 4));
      checkOutput($sformatf("count%0d.idle", k), 32'(set_idle), (k == 12) ? 32'd1 : 32'd0);
    end
    checkOutput("expire.mode", 32'(timer_mode), 32'd1);
    applyStimulus(0, 1);
    checkAll("after_expire", 0, 0, 0, 0);

    // Four presses two cycles apart: 1 -> 2 -> 3 -> off.
    applyStimulus(1, 1);
    checkAll("p1", 1, 3, 0, 1);
    applyStimulus(0, 1);
    applyStimulus(1, 1);
    checkAll("p2", 2, 5, 0, 1);
    applyStimulus(0, 1);
    applyStimulus(1, 1);
    checkAll("p3", 3, 7, 0, 1);
    applyStimulus(0, 1);
    applyStimulus(1, 1);
    checkAll("p4", 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1);
      checkOutput("p4_quiet.idle", 32'(set_idle), 32'd0);
    end

    // Press coinciding with the tick that would take remain from 2 to 1.
    applyStimulus(1, 1);
    for (int k = 1; k <= 7; k++) applyStimulus(0, 1);
    checkOutput("pre_coinc.remain", 32'(remain_s), 32'd2);
    applyStimulus(1, 1);
    checkAll("coinc", 2, 5, 0, 1);
    for (int k = 1; k <= 3; k++) applyStimulus(0, 1);
    checkOutput("coinc+3.remain", 32'(remain_s), 32'd5);
    applyStimulus(0, 1);
    checkOutput("coinc+4.remain", 32'(remain_s), 32'd4);
    applyStimulus(0, 0);
    checkAll("coinc_cancel", 0, 0, 0, 0);

    // fan_en drops at remain=1: silent cancel, presses ignored while low.
    applyStimulus(1, 1);
    for (int k = 1; k <= 8; k++) applyStimulus(0, 1);
    checkOutput("pre_drop.remain", 32'(remain_s), 32'd1);
    applyStimulus(0, 0);
    checkAll("drop", 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0);
      checkOutput("drop_quiet.idle", 32'(set_idle), 32'd0);
    end
    applyStimulus(1, 0);
    checkAll("press_fan_off", 0, 0, 0, 0);
    applyStimulus(0, 1);
    checkAll("fan_back", 0, 0, 0, 0);

    // Press during the EXPIRE cycle is ignored; a later press restarts mode 1.
    applyStimulus(1, 1);
    for (int k = 1; k <= 12; k++) applyStimulus(0, 1);
    checkAll("expire2", 1, 0, 1, 0);
    applyStimulus(1, 1);
    checkAll("expire_press", 0, 0, 0, 0);
    applyStimulus(0, 1);
    checkAll("expire_press+1", 0, 0, 0, 0);
    applyStimulus(1, 1);
    checkAll("restart", 1, 3, 0, 1);

    // Reset in the middle of a run: everything clears, no pulse afterwards.
    for (int k = 1; k <= 5; k++) applyStimulus(0, 1);
    reset_p = 1'b1;
    applyStimulus(0, 1);
    checkAll("reset_mid", 0, 0, 0, 0);
    reset_p = 1'b0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(0, 1);
      checkOutput("post_reset.idle", 32'(set_idle), 32'd0);
      checkOutput("post_reset.mode", 32'(timer_mode), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
